// File: rtl/mtm_alu_serial_n_if.sv
// Serial link bundle for mtm_alu_serial_n: one input and one output bit stream.
interface mtm_alu_serial_n_if;
    logic sin;
    logic sout;

    modport master (output sin, input  sout);
    modport slave  (input  sin, output sout);
endinterface

// File: rtl/mtm_alu_serial_n.sv
// Serial-link ALU: deserialises two NBYTES operands plus a command frame,
// validates frame count / CRC4 / opcode and returns either a result packet
// (R, flags, CRC3) or a single parity-protected error frame.
module mtm_alu_serial_n #(
    parameter int NBYTES  = 4,
    parameter int EN_XOR  = 0,
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    mtm_alu_serial_n_if.slave bus
);
    localparam int W     = 8 * NBYTES;
    localparam int NDATA = 2 * NBYTES;
    localparam int CW    = $clog2(NDATA + 2);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int FW    = $clog2(NBYTES + 1);

    typedef enum logic [2:0] {RX_IDLE, RX_TYPE, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_TYPE, TX_BITS, TX_STOP} tx_state_t;

    function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic b);
        logic fb;
        fb = c[3] ^ b;
        return {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    endfunction

    function automatic logic [2:0] crc3_step(input logic [2:0] c, input logic b);
        logic fb;
        fb = c[2] ^ b;
        return {c[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
    endfunction

    // receive side state
    rx_state_t      r_rx_st;
    logic           r_type;
    logic [2:0]     r_rx_bit;
    logic [7:0]     r_byte;
    logic [2*W-1:0] r_ab;
    logic [CW-1:0]  r_cnt;
    logic [TW-1:0]  r_tmo;
    logic [3:0]     r_crc4;

    // pending result handed from Rx to Tx
    logic           r_pend;
    logic           r_pend_err;
    logic [W-1:0]   r_pend_r;
    logic [7:0]     r_pend_ctl;

    // transmit side state
    tx_state_t      r_tx_st;
    logic           r_sout;
    logic [W-1:0]   r_tx_r;
    logic [7:0]     r_tx_ctl;
    logic           r_tx_err;
    logic [FW-1:0]  r_tx_idx;
    logic [2:0]     r_tx_bit;
    logic [2:0]     r_crc3;

    logic           w_crc_en;
    logic           w_crc_bit;
    logic [W-1:0]   w_a, w_b, w_r;
    logic [W:0]     w_sum, w_diff;
    logic [2:0]     w_op;
    logic           w_op_ok, w_c, w_o;
    logic [3:0]     w_flags;
    logic [5:0]     w_err;
    logic           w_is_err;
    logic           w_ctl_done;
    logic           w_tx_take;
    logic           w_tx_ctl;
    logic [7:0]     w_tx_byte;
    logic           w_tx_val;

    // CRC4 feed: every data bit, then '1' in place of the ignored ctl bit7, then op
    always_comb begin
        w_crc_en  = 1'b0;
        w_crc_bit = bus.sin;
        if (r_rx_st == RX_DATA) begin
            if (!r_type) begin
                w_crc_en = 1'b1;
            end else if (r_rx_bit == 3'd0) begin
                w_crc_en  = 1'b1;
                w_crc_bit = 1'b1;
            end else if (r_rx_bit <= 3'd3) begin
                w_crc_en = 1'b1;
            end
        end
    end

    // ALU result, flags and prioritised error classification of the received packet
    always_comb begin
        w_a     = r_ab[2*W-1:W];
        w_b     = r_ab[W-1:0];
        w_op    = r_byte[6:4];
        w_sum   = {1'b0, w_a} + {1'b0, w_b};
        w_diff  = {1'b0, w_a} - {1'b0, w_b};
        w_r     = '0;
        w_c     = 1'b0;
        w_o     = 1'b0;
        w_op_ok = 1'b1;
        case (w_op)
            3'b000: w_r = w_a & w_b;
            3'b001: w_r = w_a | w_b;
            3'b010: begin
                w_r     = w_a ^ w_b;
                w_op_ok = (EN_XOR != 0);
            end
            3'b100: begin
                w_r = w_sum[W-1:0];
                w_c = w_sum[W];
                w_o = (w_a[W-1] == w_b[W-1]) && (w_sum[W-1] != w_a[W-1]);
            end
            3'b101: begin
                w_r = w_diff[W-1:0];
                w_c = w_diff[W];
                w_o = (w_a[W-1] != w_b[W-1]) && (w_diff[W-1] != w_a[W-1]);
            end
            default: w_op_ok = 1'b0;
        endcase
        w_flags = {w_c, w_o, (w_r == '0), w_r[W-1]};
        if (r_cnt != CW'(NDATA))
            w_err = 6'b100100;
        else if (r_byte[3:0] != r_crc4)
            w_err = 6'b010010;
        else if (!w_op_ok)
            w_err = 6'b001001;
        else
            w_err = 6'b000000;
        w_is_err = (w_err != 6'b000000);
    end

    assign w_ctl_done = (r_rx_st == RX_STOP) && bus.sin && r_type;

    // Rx deserialiser: frame FSM, byte counter, operand shift register, CRC4, timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_st  <= RX_IDLE;
            r_type   <= 1'b0;
            r_rx_bit <= '0;
            r_byte   <= '0;
            r_ab     <= '0;
            r_cnt    <= '0;
            r_tmo    <= '0;
            r_crc4   <= '0;
        end else begin
            case (r_rx_st)
                RX_IDLE: begin
                    if (!bus.sin) begin
                        r_rx_st <= RX_TYPE;
                        r_tmo   <= '0;
                    end else if (r_cnt != '0) begin
                        if (r_tmo == TW'(TIMEOUT - 1)) begin
                            r_cnt  <= '0;
                            r_ab   <= '0;
                            r_crc4 <= '0;
                            r_tmo  <= '0;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                end
                RX_TYPE: begin
                    r_type   <= bus.sin;
                    r_rx_bit <= '0;
                    r_rx_st  <= RX_DATA;
                end
                RX_DATA: begin
                    r_byte <= {r_byte[6:0], bus.sin};
                    if (w_crc_en)
                        r_crc4 <= crc4_step(r_crc4, w_crc_bit);
                    r_rx_bit <= r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7)
                        r_rx_st <= RX_STOP;
                end
                RX_STOP: begin
                    if (bus.sin) begin
                        if (!r_type) begin
                            r_ab <= {r_ab[2*W-9:0], r_byte};
                            if (r_cnt != CW'(NDATA + 1))
                                r_cnt <= r_cnt + 1'b1;
                        end else begin
                            r_cnt  <= '0;
                            r_ab   <= '0;
                            r_crc4 <= '0;
                        end
                        r_rx_st <= RX_IDLE;
                    end else begin
                        r_cnt   <= '0;
                        r_ab    <= '0;
                        r_crc4  <= '0;
                        r_rx_st <= RX_WAIT;
                    end
                end
                RX_WAIT: begin
                    if (bus.sin)
                        r_rx_st <= RX_IDLE;
                end
                default: r_rx_st <= RX_IDLE;
            endcase
        end
    end

    assign w_tx_take = (r_tx_st == TX_IDLE) && r_pend;

    // One-deep pending slot: loaded on every ctl frame, released when Tx picks it up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend     <= 1'b0;
            r_pend_err <= 1'b0;
            r_pend_r   <= '0;
            r_pend_ctl <= '0;
        end else begin
            assert (!(w_ctl_done && r_pend && !w_tx_take));
            if (w_ctl_done) begin
                r_pend     <= 1'b1;
                r_pend_err <= w_is_err;
                r_pend_r   <= w_r;
                r_pend_ctl <= w_is_err ? {1'b1, w_err, ^{1'b1, w_err}}
                                       : {1'b0, w_flags, 3'b000};
            end else if (w_tx_take) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign w_tx_ctl  = r_tx_err || (r_tx_idx == FW'(NBYTES));
    assign w_tx_byte = w_tx_ctl ? r_tx_ctl : r_tx_r[W-1 -: 8];
    assign w_tx_val  = (w_tx_ctl && !r_tx_err && (r_tx_bit < 3'd3)) ? r_crc3[r_tx_bit]
                                                                   : w_tx_byte[r_tx_bit];

    // Tx serialiser: CRC3 accumulates over outgoing R bits and the ctl prefix {0, flags}
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_st  <= TX_IDLE;
            r_sout   <= 1'b1;
            r_tx_r   <= '0;
            r_tx_ctl <= '0;
            r_tx_err <= 1'b0;
            r_tx_idx <= '0;
            r_tx_bit <= '0;
            r_crc3   <= '0;
        end else begin
            case (r_tx_st)
                TX_IDLE: begin
                    r_sout <= 1'b1;
                    if (r_pend) begin
                        r_tx_r   <= r_pend_r;
                        r_tx_ctl <= r_pend_ctl;
                        r_tx_err <= r_pend_err;
                        r_tx_idx <= '0;
                        r_crc3   <= '0;
                        r_tx_st  <= TX_START;
                    end
                end
                TX_START: begin
                    r_sout  <= 1'b0;
                    r_tx_st <= TX_TYPE;
                end
                TX_TYPE: begin
                    r_sout   <= w_tx_ctl;
                    r_tx_bit <= 3'd7;
                    r_tx_st  <= TX_BITS;
                end
                TX_BITS: begin
                    r_sout <= w_tx_val;
                    if (!w_tx_ctl || (r_tx_bit >= 3'd3))
                        r_crc3 <= crc3_step(r_crc3, w_tx_val);
                    if (r_tx_bit == 3'd0)
                        r_tx_st <= TX_STOP;
                    else
                        r_tx_bit <= r_tx_bit - 3'd1;
                end
                TX_STOP: begin
                    r_sout <= 1'b1;
                    if (w_tx_ctl) begin
                        r_tx_st <= TX_IDLE;
                    end else begin
                        r_tx_idx <= r_tx_idx + 1'b1;
                        r_tx_r   <= r_tx_r << 8;
                        r_tx_st  <= TX_START;
                    end
                end
                default: r_tx_st <= TX_IDLE;
            endcase
        end
    end

    assign bus.sout = r_sout;
endmodule

// File: tb/tb_mtm_alu_serial_n.sv
// Bench for mtm_alu_serial_n: three builds (4-byte, 4-byte with XOR, 2-byte)
// driven with directed and random packets, checked against a frame-level model.
module tb_mtm_alu_serial_n;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic tb_sin = 1'b1;
    int   sel = 0;
    int   nb_cur = 4;
    bit   xor_cur = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_stop = 0;

    mtm_alu_serial_n_if if0();
    mtm_alu_serial_n_if if1();
    mtm_alu_serial_n_if if2();
    assign if0.sin = (sel == 0) ? tb_sin : 1'b1;
    assign if1.sin = (sel == 1) ? tb_sin : 1'b1;
    assign if2.sin = (sel == 2) ? tb_sin : 1'b1;

    mtm_alu_serial_n #(.NBYTES(4), .EN_XOR(0), .TIMEOUT(TMO)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    mtm_alu_serial_n #(.NBYTES(4), .EN_XOR(1), .TIMEOUT(TMO)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    mtm_alu_serial_n #(.NBYTES(2), .EN_XOR(0), .TIMEOUT(TMO)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic mon_sout;
    assign mon_sout = (sel == 0) ? if0.sout : (sel == 1) ? if1.sout : if2.sout;

    always @(posedge clk) cyc <= cyc + 1;

    // response monitor: frames as {type, byte}, plus the cycle of each start bit
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    int         starts_q[$];
    int         m_ph = 0;
    logic [8:0] m_sh = '0;
    bit         m_stop_bad = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            m_ph = 0;
        end else if (m_ph == 0) begin
            if (mon_sout == 1'b0) begin
                m_ph = 1;
                starts_q.push_back(cyc);
            end
        end else if (m_ph <= 9) begin
            m_sh = {m_sh[7:0], mon_sout};
            m_ph++;
        end else begin
            got_q.push_back(m_sh);
            if (mon_sout !== 1'b1) m_stop_bad = 1'b1;
            m_ph = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // generic MSB-first serial CRC of width n, init 0
    function automatic int crc_gen(input bit bits[$], input int n, input int poly);
        int c = 0;
        foreach (bits[i]) begin
            int fb = ((c >> (n - 1)) & 1) ^ int'(bits[i]);
            c = ((c << 1) & ((1 << n) - 1)) ^ (fb != 0 ? poly : 0);
        end
        return c;
    endfunction

    function automatic logic [3:0] m_crc4(input longint unsigned a, input longint unsigned b,
                                          input logic [2:0] op, input int nb);
        bit q[$];
        for (int i = 8 * nb - 1; i >= 0; i--) q.push_back(a[i]);
        for (int i = 8 * nb - 1; i >= 0; i--) q.push_back(b[i]);
        q.push_back(1'b1);
        for (int i = 2; i >= 0; i--) q.push_back(op[i]);
        return 4'(crc_gen(q, 4, 3));
    endfunction

    function automatic logic [2:0] m_crc3(input longint unsigned r, input logic [3:0] fl, input int nb);
        bit q[$];
        for (int i = 8 * nb - 1; i >= 0; i--) q.push_back(r[i]);
        q.push_back(1'b0);
        for (int i = 3; i >= 0; i--) q.push_back(fl[i]);
        return 3'(crc_gen(q, 3, 3));
    endfunction

    function automatic longint to_signed(input longint unsigned v, input int w);
        longint s = longint'(v);
        if (v[w - 1]) s = s - (longint'(1) << w);
        return s;
    endfunction

    // expected response frames for one input packet
    task automatic expect_pkt(input longint unsigned a, input longint unsigned b, input logic [2:0] op,
                              input int ndata, input bit badcrc);
        int w = 8 * nb_cur;
        longint unsigned mask = (64'd1 << w) - 1;
        longint lo = -(longint'(1) << (w - 1));
        longint hi = (longint'(1) << (w - 1)) - 1;
        longint sa = to_signed(a, w);
        longint sb = to_signed(b, w);
        longint unsigned r = 0;
        bit cf = 1'b0, of = 1'b0;
        logic [3:0] fl;
        if (ndata != 2 * nb_cur) exp_q.push_back({1'b1, 8'hC9});
        else if (badcrc) exp_q.push_back({1'b1, 8'hA5});
        else if (!(op == 0 || op == 1 || op == 4 || op == 5 || (op == 2 && xor_cur)))
            exp_q.push_back({1'b1, 8'h93});
        else begin
            case (op)
                3'd0: r = a & b;
                3'd1: r = a | b;
                3'd2: r = a ^ b;
                3'd4: begin
                    r  = (a + b) & mask;
                    cf = ((a + b) >> w) != 0;
                    of = (sa + sb < lo) || (sa + sb > hi);
                end
                default: begin
                    r  = (a - b) & mask;
                    cf = a < b;
                    of = (sa - sb < lo) || (sa - sb > hi);
                end
            endcase
            fl = {cf, of, r == 0, r[w - 1]};
            for (int i = nb_cur - 1; i >= 0; i--) exp_q.push_back({1'b0, 8'((r >> (8 * i)) & 255)});
            exp_q.push_back({1'b1, 1'b0, fl, m_crc3(r, fl, nb_cur)});
        end
    endtask

    task automatic bitout(input logic b);
        tb_sin = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bitout(1'b1);
    endtask

    task automatic send_frame(input logic t, input logic [7:0] d);
        bitout(1'b0);
        bitout(t);
        for (int i = 7; i >= 0; i--) bitout(d[i]);
        bitout(1'b1);
    endtask

    task automatic send_data(input longint unsigned a, input longint unsigned b, input int i);
        int k = i % (2 * nb_cur);
        longint unsigned v = (k < nb_cur) ? a : b;
        int bi = nb_cur - 1 - (k % nb_cur);
        send_frame(1'b0, 8'((v >> (8 * bi)) & 255));
    endtask

    task automatic pkt(input longint unsigned a, input longint unsigned b, input logic [2:0] op,
                       input int ndata, input bit badcrc, input int gap_at, input int gap_len);
        logic [3:0] c4 = m_crc4(a, b, op, nb_cur) ^ {3'b000, badcrc};
        expect_pkt(a, b, op, ndata, badcrc);
        for (int i = 0; i < ndata; i++) begin
            send_data(a, b, i);
            if (i == gap_at) idle(gap_len);
        end
        send_frame(1'b1, {1'($urandom), op, c4});
        last_stop = cyc;
        $display("[TB] dut%0d sent A=%0h B=%0h op=%0d frames=%0d badcrc=%0d", sel, a, b, op, ndata, badcrc);
    endtask

    task automatic collect(input string tag, input bit chk_lat, input bit chk_b2b);
        int budget = 0;
        while (got_q.size() < exp_q.size() && budget < 2000) begin
            bitout(1'b1);
            budget++;
        end
        idle(30);
        check({tag, "/count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s/frame%0d", tag, i), got_q[i], exp_q[i]);
        if (chk_lat && starts_q.size() > 0)
            check({tag, "/latency"}, starts_q[0] - last_stop, 2);
        if (chk_b2b)
            for (int i = 1; i < starts_q.size(); i++)
                check($sformatf("%s/spacing%0d", tag, i), starts_q[i] - starts_q[i - 1], 11);
        check({tag, "/stopbits"}, m_stop_bad, 0);
        $display("[TB] %s: %0d response frames", tag, got_q.size());
        got_q.delete();
        exp_q.delete();
        starts_q.delete();
        m_stop_bad = 1'b0;
    endtask

    task automatic use_dut(input int s, input int nb, input bit ex);
        sel = s;
        nb_cur = nb;
        xor_cur = ex;
        idle(3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset/sout0", if0.sout, 1'b1);
        check("reset/sout1", if1.sout, 1'b1);
        check("reset/sout2", if2.sout, 1'b1);
        rst = 1'b0;
        idle(4);
        check("post_reset/sout0", if0.sout, 1'b1);

        use_dut(0, 4, 1'b0);
        pkt(5, 3, 3'b100, 8, 0, -1, 0);                 collect("add_5_3", 1, 1);
        pkt(0, 1, 3'b101, 8, 0, -1, 0);                 collect("sub_0_1", 1, 1);
        pkt(64'h7FFFFFFF, 1, 3'b100, 8, 0, -1, 0);      collect("add_ovf", 1, 1);
        pkt(64'h12345678, 64'h9ABCDEF0, 3'b100, 7, 0, -1, 0); collect("err_data7", 1, 1);
        pkt(64'h12345678, 64'h9ABCDEF0, 3'b001, 8, 1, -1, 0); collect("err_crc", 1, 1);
        pkt(64'h0000FFFF, 64'h00FF00FF, 3'b111, 8, 0, -1, 0); collect("err_op7", 1, 1);
        pkt(64'hF0F0F0F0, 64'hFF00FF00, 3'b010, 8, 0, -1, 0); collect("err_xor_off", 1, 1);

        // partial packet abandoned by timeout, then a valid packet
        for (int i = 0; i < 3; i++) send_data(64'hAAAAAAAA, 64'h55555555, i);
        idle(TMO);
        pkt(64'h00000100, 64'h00000011, 3'b000, 8, 0, -1, 0); collect("timeout_discard", 1, 1);

        // gap one below the timeout keeps the packet alive
        pkt(64'hDEADBEEF, 64'h01234567, 3'b101, 8, 0, 3, TMO - 1); collect("timeout_edge", 1, 1);

        // zero gap between two packets
        pkt(64'h00000010, 64'h00000020, 3'b001, 8, 0, -1, 0);
        pkt(64'h80000000, 64'h80000000, 3'b100, 8, 0, -1, 0); collect("back_to_back", 0, 0);

        for (int k = 0; k < 6; k++) begin
            pkt({32'd0, $urandom}, {32'd0, $urandom}, 3'($urandom_range(0, 7)), 8,
                ($urandom_range(0, 3) == 0), -1, 0);
            collect($sformatf("rand0_%0d", k), 1, 1);
        end

        // reset during the fifth input frame
        for (int i = 0; i < 4; i++) send_data(64'h11111111, 64'h22222222, i);
        bitout(1'b0); bitout(1'b0); bitout(1'b1); bitout(1'b0);
        rst = 1'b1;
        #1;
        check("rst_rx/sout", mon_sout, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        idle(3);
        got_q.delete(); starts_q.delete();
        pkt(64'h00000007, 64'h00000009, 3'b100, 8, 0, -1, 0); collect("after_rst_rx", 1, 1);

        // reset during the second response frame: sout must rise without a clock edge
        pkt(64'h0000FFFF, 64'h0000FFFF, 3'b000, 8, 0, -1, 0);
        for (int i = 0; i < 200 && starts_q.size() < 2; i++) bitout(1'b1);
        check("rst_tx/mid_frame", starts_q.size() >= 2, 1'b1);
        check("rst_tx/sout_low", mon_sout, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_tx/sout_async", mon_sout, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        idle(20);
        check("rst_tx/quiet", got_q.size() + starts_q.size() >= 1 && mon_sout === 1'b1, 1'b1);
        got_q.delete(); exp_q.delete(); starts_q.delete();
        pkt(64'h00000003, 64'h00000004, 3'b101, 8, 0, -1, 0); collect("after_rst_tx", 1, 1);

        use_dut(1, 4, 1'b1);
        pkt(64'hF0F0F0F0, 64'hFF00FF00, 3'b010, 8, 0, -1, 0); collect("xor_on", 1, 1);
        for (int k = 0; k < 3; k++) begin
            pkt({32'd0, $urandom}, {32'd0, $urandom}, 3'($urandom_range(0, 7)), 8, 0, -1, 0);
            collect($sformatf("rand1_%0d", k), 1, 1);
        end

        use_dut(2, 2, 1'b0);
        pkt(64'h8000, 64'h8000, 3'b100, 4, 0, -1, 0);   collect("nb2_add", 1, 1);
        pkt(64'h1234, 64'h5678, 3'b100, 3, 0, -1, 0);   collect("nb2_err_data", 1, 1);
        for (int k = 0; k < 4; k++) begin
            pkt({48'd0, 16'($urandom)}, {48'd0, 16'($urandom)}, 3'($urandom_range(0, 7)), 4,
                ($urandom_range(0, 3) == 0), -1, 0);
            collect($sformatf("rand2_%0d", k), 1, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mtm_alu_serial_n.md
# mtm_alu_serial_n

Parametrised serial-link ALU: the next generation of the team's `mtm_Alu`. It deserialises two NBYTES-wide operands plus a command frame from `sin`, and checks frame count, CRC4 and opcode. It then computes AND/OR/ADD/SUB (optionally XOR) and serialises either a result packet with flags and CRC3, or a single error frame, on `sout`. Additions over the fixed 32-bit block: operand width is generic, CRCs are computed bit-serially, XOR is a build option, and an inter-frame timeout discards stalled packets.

## Interface
- NBYTES, 4: bytes per operand; W = 8*NBYTES.
- EN_XOR, 0: 1 makes opcode 3'b010 a valid XOR.
- TIMEOUT, 64: idle `sin`=1 cycles between frames of a started packet before it is discarded.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- sin  in  1  serial input, idle high, one bit per clk.
- sout  out  1  serial output, idle high, one bit per clk.

## Operation
- Frame, 11 bits: start 0, type (0 = data, 1 = ctl), d[7:0] MSB first, stop 1. `sin` is sampled on posedge.
- Input packet:
  - 2*NBYTES data frames: A MSB byte first, then B.
  - One ctl frame `{x, op[2:0], crc4[3:0]}`; bit7 is ignored.
- Rx FSM: IDLE → TYPE → DATA(8) → STOP → IDLE.
  - If STOP samples 0 (framing error), discard the packet silently and wait for `sin`=1 before returning to IDLE.
- Data byte counter saturates at 2*NBYTES+1. Bytes are shifted into a 2W register.
- Timeout counter runs in IDLE while a packet is partially received. It clears on each start bit. At TIMEOUT it discards the packet silently.
- On a ctl frame, checks are evaluated in priority order. Exactly one error is reported; counters clear.
  - Data error: count != 2*NBYTES. err_flags = 6'b100100.
  - CRC error: crc4 mismatch. err_flags = 6'b010010.
  - Op error: op not in {000 and, 001 or, 100 add, 101 sub, 010 xor if EN_XOR}. err_flags = 6'b001001.
- crc4 is computed over the 2W+4 bit string {A, B, 1'b1, op}, MSB first.
  - Polynomial x^4+x+1, init 0.
  - Per bit: fb = c[3]^b; c = {c[2:0],0} ^ (fb ? 4'b0011 : 0).
  - Computed serially while bits arrive, one bit per cycle, then over the 4 trailer bits.
- Arithmetic is W-bit two's complement:
  - C (bit 3), carry: bit W of {0,A}+{0,B} for add; bit W of {0,A}-{0,B} (borrow) for sub; 0 for logic ops.
  - O (bit 2), signed overflow: add, A[W-1]=B[W-1]≠R[W-1]; sub, A[W-1]≠B[W-1] and R[W-1]≠A[W-1]; 0 for logic ops.
  - Z (bit 1): R == 0.
  - N (bit 0): R[W-1].
- Result packet:
  - NBYTES data frames, R MSB byte first.
  - Then one ctl frame {0, flags[3:0], crc3}.
  - crc3 is over {R, 1'b0, flags}: polynomial x^3+x+1, init 0, same serial scheme with feedback 3'b011.
- Error packet: a single ctl frame {1, err_flags[5:0], p}. p makes the parity of all 8 bits even.
- Tx FSM: IDLE → START → TYPE → BITS(8) → STOP. A byte counter selects the next byte.
- Rx and Tx are independent. A one-deep pending register holds the result until Tx is IDLE.
  - Input packet length ≥ 11*(2*NBYTES+1) exceeds response length, so the pending register cannot overflow.
  - An overwrite while pending is an assertion failure.

## Timing
- Reset: `sout`=1; FSMs IDLE; all counters, CRCs, pending flag and shift registers 0.
  - Reset mid-packet or mid-transmission aborts immediately. `sout` returns to 1 asynchronously.
- Response latency: the first `sout` start bit is driven 2 cycles after the ctl frame's stop bit is sampled, when Tx is idle.
- Response frames are back-to-back: the next start bit directly follows the previous stop bit.
- `sout` changes only on posedge.
- The minimum gap between input packets is 0: a start bit may immediately follow a ctl stop bit.
- Timeout is measured in clk cycles after the last stop bit. Count TIMEOUT-1 still continues the packet.

## Test plan
- NBYTES=4, A=5, B=3, add, correct CRC → R=0x00000008, flags 4'b0000; crc3 matches the model.
- sub, A=0, B=1 → R=0xFFFFFFFF, flags 4'b1001. add, A=0x7FFFFFFF, B=1 → R=0x80000000, flags 4'b0101.
- Error frames:
  - 7 data frames then ctl → single frame 0xC9.
  - crc4 LSB flipped → 0xA5.
  - op=3'b111 with valid CRC → 0x93.
  - op=3'b010 with EN_XOR=0 → 0x93; with EN_XOR=1, A=0xF0F0F0F0, B=0xFF00FF00 → R=0x0FF00FF0, flags 4'b0000.
- NBYTES=2, A=0x8000, B=0x8000, add → R=0x0000, flags 4'b1110; 3 frames out.
- Robustness:
  - 3 data frames, then TIMEOUT idle cycles, then a full valid packet → only the valid response.
  - rst asserted during the 5th frame → `sout`=1; the next packet is processed normally.
